// File: rtl/uart_msg_pkg.sv
// -----------------------------------------------------------------------------
// uart_msg_pkg
// Shared constants, FSM state encoding and small helpers for temp_msg_tx and
// its bin2bcd_seq converter.
//
// Build option:
//   TEMP_MSG_CRLF_EN  when defined, every message is terminated with CR LF
//                     (7 bytes); otherwise the message is "DDD.D" (5 bytes).
// -----------------------------------------------------------------------------
package uart_msg_pkg;

    // Input reading width; 14 bits is the smallest width that holds 9999.
    localparam int unsigned DATA_W  = 14;
    // Readings above this are clamped before conversion.
    localparam int unsigned MAX_VAL = 9999;
    // Four packed BCD digits.
    localparam int unsigned BCD_W   = 16;
    // Shift counter width; must count 0..DATA_W-1.
    localparam int unsigned CNT_W   = 4;
    // Byte index width; must count 0..MSG_LEN-1.
    localparam int unsigned IDX_W   = 3;

    localparam logic [7:0] ASC_ZERO = 8'h30;
    localparam logic [7:0] ASC_DOT  = 8'h2E;
    localparam logic [7:0] ASC_CR   = 8'h0D;
    localparam logic [7:0] ASC_LF   = 8'h0A;

`ifdef TEMP_MSG_CRLF_EN
    localparam int unsigned MSG_LEN = 7;
`else
    localparam int unsigned MSG_LEN = 5;
`endif

    // Handshake FSM states (3-bit encoding).
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONV    = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_NEXT    = 3'd5,
        ST_FIN     = 3'd6
    } state_e;

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        logic [3:0]       nib;
        res = '0;
        nib = '0;
        for (int i = 0; i < 4; i++) begin
            nib = bcd[4*i +: 4];
            res[4*i +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
        end
        return res;
    endfunction

    // ASCII character of one decimal digit.
    function automatic logic [7:0] digit_ascii(input logic [3:0] nib);
        return ASC_ZERO + 8'(nib);
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Iterative 14-bit binary to 4-digit BCD converter (shift-and-add-3). One
// iteration per clock; the result is valid when done pulses and is held
// until the next start.
//
// Ports:
//   sys_clk    in   clock
//   sys_rst_n  in   asynchronous active-low reset
//   start      in   load bin, clear BCD and shift counter
//   bin        in   DATA_W binary value (must be <= 9999)
//   busy       out  iterations in progress
//   done       out  one-cycle pulse after the last iteration
//   bcd        out  BCD_W packed result {thousands, hundreds, tens, units}
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import uart_msg_pkg::*;
(
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BCD_W-1:0]  adj_c;

    // Next-state: load on start, otherwise one adjust+shift per busy cycle.
    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        adj_c  = bcd_adjust(bcd_q);

        if (start) begin
            bin_d  = bin;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // The binary MSB shifts into the BCD LSB.
            {bcd_d, bin_d} = {adj_c, bin_q} << 1;
            cnt_d          = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/temp_msg_tx.sv
// -----------------------------------------------------------------------------
// temp_msg_tx
// Converts a temperature reading (tenths of a degree) to the ASCII message
// "DDD.D" and feeds it one byte at a time to a UART byte transmitter using
// the uart_en / uart_din / uart_tx_busy handshake.
//
// Build option:
//   TEMP_MSG_CRLF_EN  append CR LF to every message (see uart_msg_pkg).
//
// Ports:
//   sys_clk       in   clock
//   sys_rst_n     in   asynchronous active-low reset
//   start         in   one-cycle request, honoured only when idle
//   temp_data     in   DATA_W unsigned reading, sampled with start
//   uart_tx_busy  in   transmitter busy flag
//   uart_en       out  byte request level (transmitter sees its rising edge)
//   uart_din      out  ASCII byte for the transmitter
//   busy          out  frame in progress
//   done          out  one-cycle pulse after the last byte completes
// -----------------------------------------------------------------------------
module temp_msg_tx
    import uart_msg_pkg::*;
(
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] temp_data,
    input  logic              uart_tx_busy,
    output logic              uart_en,
    output logic [7:0]        uart_din,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              uart_en_q, uart_en_d;
    logic [7:0]        uart_din_q, uart_din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              conv_start_c;
    logic              conv_busy_c;
    logic              conv_done_c;
    logic [BCD_W-1:0]  bcd_c;
    logic [DATA_W-1:0] sat_c;
    logic [7:0]        msg_byte_c;

    // Clamp out-of-range readings so the 4-digit result stays valid.
    assign sat_c = (temp_data > DATA_W'(MAX_VAL)) ? DATA_W'(MAX_VAL) : temp_data;

    // The converter's own registers hold the sampled reading.
    bin2bcd_seq u_bin2bcd (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (conv_start_c),
        .bin       (sat_c),
        .busy      (conv_busy_c),
        .done      (conv_done_c),
        .bcd       (bcd_c)
    );

    // Message byte for the current index; leading zeros are kept.
    always_comb begin
        msg_byte_c = 8'h00;
        case (idx_q)
            IDX_W'(0): msg_byte_c = digit_ascii(bcd_c[15:12]);
            IDX_W'(1): msg_byte_c = digit_ascii(bcd_c[11:8]);
            IDX_W'(2): msg_byte_c = digit_ascii(bcd_c[7:4]);
            IDX_W'(3): msg_byte_c = ASC_DOT;
            IDX_W'(4): msg_byte_c = digit_ascii(bcd_c[3:0]);
`ifdef TEMP_MSG_CRLF_EN
            IDX_W'(5): msg_byte_c = ASC_CR;
            IDX_W'(6): msg_byte_c = ASC_LF;
`endif
            default:   msg_byte_c = 8'h00;
        endcase
    end

    // Handshake FSM next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        uart_en_d    = uart_en_q;
        uart_din_d   = uart_din_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        conv_start_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !conv_busy_c) begin
                    conv_start_c = 1'b1;
                    busy_d       = 1'b1;
                    idx_d        = '0;
                    state_d      = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_done_c) begin
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                uart_din_d = msg_byte_c;
                uart_en_d  = 1'b1;
                state_d    = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                // Keep the request up until the transmitter has taken it.
                if (uart_tx_busy) begin
                    uart_en_d = 1'b0;
                    state_d   = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!uart_tx_busy) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // Passing through here guarantees a low cycle of uart_en,
                // so every byte presents a fresh rising edge.
                if (idx_q == IDX_W'(MSG_LEN - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_SEND;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            uart_en_q  <= 1'b0;
            uart_din_q <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            uart_en_q  <= uart_en_d;
            uart_din_q <= uart_din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign uart_en  = uart_en_q;
    assign uart_din = uart_din_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_temp_msg_tx.sv
// -----------------------------------------------------------------------------
// tb_temp_msg_tx
// Self-checking bench for temp_msg_tx. A transmitter model answers each
// uart_en rising edge with a configurable busy pulse; a protocol-level model
// predicts busy/done/uart_en/uart_din every cycle from the message rules.
// Honours TEMP_MSG_CRLF_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_temp_msg_tx;

`ifdef TEMP_MSG_CRLF_EN
    localparam int TB_MSG_LEN = 7;
`else
    localparam int TB_MSG_LEN = 5;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic [13:0] temp_data;
    logic        uart_tx_busy;
    logic        uart_en;
    logic [7:0]  uart_din;
    logic        busy;
    logic        done;

    temp_msg_tx dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
        .temp_data    (temp_data),
        .uart_tx_busy (uart_tx_busy),
        .uart_en      (uart_en),
        .uart_din     (uart_din),
        .busy         (busy),
        .done         (done)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;

    // Transmitter model knobs
    int tx_delay = 3;
    int tx_len   = 20;
    bit tx_stall = 1'b0;

    // Bytes captured at each uart_en rising edge
    logic [7:0] rx_log[$];
    int         rise_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected message byte i for reading t, straight from the message rules.
    function automatic int msg_byte(input int t, input int i);
        int v;
        v = (t > 9999) ? 9999 : t;
        case (i)
            0: return 48 + v / 1000;
            1: return 48 + (v / 100) % 10;
            2: return 48 + (v / 10) % 10;
            3: return 46;
            4: return 48 + v % 10;
            5: return 13;
            6: return 10;
            default: return 0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Transmitter model: after a uart_en rise, wait tx_delay cycles (and
    // while tx_stall), then hold busy for tx_len cycles.
    // ------------------------------------------------------------------
    int tx_phase = 0;
    int tx_cnt   = 0;
    bit tx_en_prev = 1'b0;

    initial begin : tx_model
        uart_tx_busy = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            case (tx_phase)
                0: if (uart_en && !tx_en_prev) begin
                       tx_phase = 1;
                       tx_cnt   = tx_delay;
                   end
                1: begin
                       if (tx_cnt > 0) tx_cnt--;
                       if (tx_cnt == 0 && !tx_stall) begin
                           uart_tx_busy = 1'b1;
                           tx_phase     = 2;
                           tx_cnt       = tx_len;
                       end
                   end
                default: begin
                       tx_cnt--;
                       if (tx_cnt <= 0) begin
                           uart_tx_busy = 1'b0;
                           tx_phase     = 0;
                       end
                   end
            endcase
            tx_en_prev = uart_en;
        end
    end

    // ------------------------------------------------------------------
    // Protocol model + per-cycle compare. Runs at negedge; s_* hold the
    // inputs that the preceding posedge sampled.
    // ------------------------------------------------------------------
    bit  m_active = 0, m_done = 0, m_en = 0, m_await_lo = 0;
    int  m_until_rise = 0, m_until_done = 0;
    int  m_byte = 0;
    int  m_q[$];
    bit  s_start = 0, s_txb = 0;
    int  s_temp = 0;
    bit  en_seen = 0;

    initial begin : compare_p
        bit was_idle;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                m_active = 0; m_done = 0; m_en = 0; m_await_lo = 0;
                m_until_rise = 0; m_until_done = 0; m_byte = 0;
                m_q.delete();
                check("rst_uart_en",  uart_en,  0);
                check("rst_uart_din", uart_din, 0);
                check("rst_busy",     busy,     0);
                check("rst_done",     done,     0);
            end else begin
                was_idle = !m_active && !m_done;
                m_done   = 0;
                if (was_idle) begin
                    if (s_start) begin
                        m_active = 1;
                        m_q.delete();
                        for (int i = 0; i < TB_MSG_LEN; i++) m_q.push_back(msg_byte(s_temp, i));
                        // First request appears on the 16th edge after acceptance.
                        m_until_rise = 16;
                    end
                end else if (m_until_rise > 0) begin
                    m_until_rise--;
                    if (m_until_rise == 0) begin
                        m_en   = 1;
                        m_byte = m_q.pop_front();
                    end
                end else if (m_until_done > 0) begin
                    m_until_done--;
                    if (m_until_done == 0) begin
                        m_done   = 1;
                        m_active = 0;
                    end
                end else if (m_en) begin
                    if (s_txb) begin
                        m_en       = 0;
                        m_await_lo = 1;
                    end
                end else if (m_await_lo) begin
                    if (!s_txb) begin
                        m_await_lo = 0;
                        if (m_q.size() == 0) m_until_done = 1;
                        else                 m_until_rise = 2;
                    end
                end
                check("uart_en", uart_en, m_en);
                check("busy",    busy,    m_active);
                check("done",    done,    m_done);
                if (m_en) check("uart_din", uart_din, m_byte);
            end
            if (uart_en && !en_seen) begin
                rx_log.push_back(uart_din);
                rise_cnt++;
            end
            en_seen = uart_en;
            s_start = start;
            s_temp  = int'(temp_data);
            s_txb   = uart_tx_busy;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic pulse_start(input int v);
        @(posedge sys_clk); #1;
        start     = 1'b1;
        temp_data = 14'(v);
        @(posedge sys_clk); #1;
        start     = 1'b0;
        temp_data = 14'($urandom);
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int k;
        k = 0;
        while (!done && k < max_cyc) begin
            @(negedge sys_clk); #1;
            k++;
        end
        check({name, "_done_seen"}, done, 1);
    endtask

    task automatic wait_rises(input string name, input int n, input int max_cyc);
        int base;
        int k;
        base = rise_cnt;
        k    = 0;
        while (rise_cnt < base + n && k < max_cyc) begin
            @(negedge sys_clk); #1;
            k++;
        end
        check({name, "_rise_seen"}, (rise_cnt >= base + n) ? 1 : 0, 1);
    endtask

    task automatic wait_en_low(input string name, input int max_cyc);
        int k;
        k = 0;
        while (uart_en && k < max_cyc) begin
            @(negedge sys_clk); #1;
            k++;
        end
        check({name, "_en_low"}, uart_en, 0);
    endtask

    // Compare the captured bytes against a hand-written message.
    task automatic check_frame(input string name, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        logic [7:0] exp[$];
        exp.push_back(b0); exp.push_back(b1); exp.push_back(b2);
        exp.push_back(b3); exp.push_back(b4);
`ifdef TEMP_MSG_CRLF_EN
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
`endif
        check({name, "_len"}, rx_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < rx_log.size()) check($sformatf("%s_byte%0d", name, i), rx_log[i], exp[i]);
        end
        rx_log.delete();
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : stim
        sys_rst_n = 1'b0;
        start     = 1'b0;
        temp_data = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("por_uart_en",  uart_en,  0);
        check("por_uart_din", uart_din, 0);
        check("por_busy",     busy,     0);
        check("por_done",     done,     0);
        sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);
        rx_log.delete();

        // Basic frame
        tx_delay = 3; tx_len = 20;
        pulse_start(1234);
        wait_done("f1234", 2000);
        check_frame("f1234", 8'h31, 8'h32, 8'h33, 8'h2E, 8'h34);
        @(negedge sys_clk); #1;
        check("idle_busy_after_done", busy, 0);

        // All zeros, leading zeros kept
        tx_delay = 2; tx_len = 5;
        pulse_start(0);
        wait_done("f0", 2000);
        check_frame("f0", 8'h30, 8'h30, 8'h30, 8'h2E, 8'h30);

        // Saturation
        pulse_start(12000);
        wait_done("fsat", 2000);
        check_frame("fsat", 8'h39, 8'h39, 8'h39, 8'h2E, 8'h39);

        // Start during WAIT_LO is ignored
        tx_delay = 3; tx_len = 20;
        pulse_start(1234);
        wait_rises("fign", 1, 100);
        wait_en_low("fign", 50);
        pulse_start(5555);
        wait_done("fign", 2000);
        check_frame("fign", 8'h31, 8'h32, 8'h33, 8'h2E, 8'h34);

        // Asynchronous reset during WAIT_HI of the second byte
        tx_delay = 3; tx_len = 8;
        pulse_start(1234);
        wait_rises("frst", 2, 500);
        @(posedge sys_clk); #2;
        check("pre_rst_uart_en", uart_en, 1);
        #1;
        sys_rst_n = 1'b0;
        #1;
        check("async_rst_uart_en", uart_en, 0);
        check("async_rst_busy",    busy,    0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        repeat (40) @(posedge sys_clk);
        rx_log.delete();
        pulse_start(42);
        wait_done("f0042", 2000);
        check_frame("f0042", 8'h30, 8'h30, 8'h34, 8'h2E, 8'h32);

        // Transmitter never goes busy: request held indefinitely
        tx_stall = 1'b1; tx_delay = 2; tx_len = 6;
        pulse_start(777);
        wait_rises("fstall", 1, 100);
        repeat (100) @(negedge sys_clk);
        check("stall_uart_en",  uart_en,  1);
        check("stall_uart_din", uart_din, 8'h30);
        check("stall_busy",     busy,     1);
        tx_stall = 1'b0;
        wait_done("fstall", 2000);
        check_frame("fstall", 8'h30, 8'h37, 8'h37, 8'h2E, 8'h37);

        // Randomized frames, spurious starts, back-to-back starts
        for (int f = 0; f < 25; f++) begin
            int v;
            tx_delay = $urandom_range(1, 5);
            tx_len   = $urandom_range(1, 12);
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9990, 16383))
                                            : int'($urandom_range(0, 9999));
            rx_log.delete();
            pulse_start(v);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 20)) @(posedge sys_clk);
                pulse_start(int'($urandom_range(0, 16383)));
            end
            wait_done($sformatf("rand%0d", f), 3000);
            check($sformatf("rand%0d_len", f), rx_log.size(), TB_MSG_LEN);
            repeat ($urandom_range(0, 3)) @(posedge sys_clk);
        end

        repeat (5) @(posedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
        $fatal(1);
    end

endmodule
